cache_ctrl_wb: RTL and testbench
================================

# cache_ctrl_wb

Parametrised successor to the single-cycle cache controller. It adds a posted write buffer, so write-through stores no longer stall the core, and a multi-beat line refill with a word counter. The block sits between the RISC-V single-cycle datapath, the cache tag/data arrays and main memory. It generates stall, refill and update strobes, and owns the main-memory request port.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- LINE_WORDS, 4, words per cache line; power of 2, ≥2
- WB_DEPTH, 4, write-buffer entries; power of 2, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- mem_read  in  1  core load request
- mem_write  in  1  core store request
- addr  in  ADDR_W  core byte address
- wdata  in  DATA_W  core store data
- hit  in  1  tag-array hit for addr (combinational)
- ready  in  1  main memory accepts/returns one beat this cycle
- stall  out  1  freeze core PC
- main_read  out  1  main-memory read request
- main_write  out  1  main-memory write request
- main_addr  out  ADDR_W  main-memory address
- main_wdata  out  DATA_W  write-buffer head data
- refill  out  1  write returned beat into data array
- refill_word  out  $clog2(LINE_WORDS)  word index of the refill beat
- refill_last  out  1  final beat; cache sets tag and valid
- update  out  1  write the core store word into the cache (write hit)
- wb_full  out  1  buffer holds WB_DEPTH entries
- wb_empty  out  1  buffer holds 0 entries

## Operation
- Policy: write-through, no-write-allocate. Reads allocate.
- States: IDLE, DRAIN, REFILL.
- IDLE, store (mem_write & !mem_read):
  - Buffer not full: push {addr, wdata}, update=hit, stall=0.
  - Buffer full: stall=1, no push, until a pop frees a slot.
- IDLE, load hit: stall=0, no main-memory activity.
- IDLE, load miss:
  - stall=1.
  - Buffer non-empty: go to DRAIN. Writes always complete before a refill.
  - Buffer empty: go to REFILL.
- mem_read & mem_write together: no-op. No push, no refill, stall=0.
- Background drain:
  - In IDLE and DRAIN, when the buffer is non-empty, main_write=1 and main_addr/main_wdata show the head entry.
  - ready pops the head.
- DRAIN:
  - stall=1.
  - When ready pops the last entry (count==1), go to REFILL.
- REFILL:
  - stall=1, main_read=1, main_write=0.
  - main_addr = {addr[ADDR_W-1:OFF], beat, 2'b00}, where OFF = $clog2(LINE_WORDS)+2.
  - Each ready: refill=1, refill_word=beat, then beat increments.
  - On ready with beat==LINE_WORDS-1: refill_last=1, beat wraps to 0, go to IDLE.
- Core inputs other than the held load are ignored outside IDLE.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo WB_DEPTH. Count width is $clog2(WB_DEPTH+1).

## Timing
- All registers (state, beat, pointers, count, buffer) update on the falling edge of clk. The core samples on the rising edge.
- All outputs are combinational from registered state and inputs.
- Reset (asserted at any time, including mid-refill or mid-drain):
  - state=IDLE, beat=0, count=0, buffer contents discarded.
  - Outputs: stall=0, main_read=0, main_write=0, refill=0, refill_last=0, update=0, wb_empty=1, wb_full=0.
- Store with a non-full buffer: zero stall cycles. The entry is visible at the head on the next falling edge if the buffer was empty.
- Load miss, empty buffer: stall lasts LINE_WORDS ready cycles plus one IDLE cycle, where hit=1 releases stall.
- Load miss, N buffered entries: N extra ready cycles of drain before REFILL.
- ready with no active request: ignored.

## Structure
- Package cache_pkg:
  - state encoding localparams (IDLE, DRAIN, REFILL);
  - function for offset width OFF;
  - write-buffer entry struct {addr, data}.
- Sub-module cache_write_buffer:
  - circular FIFO, WB_DEPTH entries;
  - push/pop, head output, full/empty/count.
- The controller FSM and beat counter stay in cache_ctrl_wb.

## Test plan
- Reset mid-REFILL at beat 2 → state IDLE, stall=0, beat=0, wb_empty=1 immediately (asynchronous).
- Four stores to 0x10..0x1C, ready held 0 → no stall, wb_full=1. Fifth store → stall=1 until one ready, then push accepted.
- Load miss at 0x44, empty buffer, ready every cycle:
  - main_addr 0x40, 0x44, 0x48, 0x4C;
  - refill_word 0..3, refill_last on beat 3;
  - stall drops in the following IDLE cycle with hit=1.
- Two buffered stores then a load miss → two main_write pops, then REFILL. No main_read before wb_empty=1.
- Store hit with the buffer draining in the same cycle (push and pop) → update=1, count unchanged, FIFO order preserved at main_wdata.
- mem_read=mem_write=1 → no push, no main_read, stall=0.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, state encoding and helpers for the write-buffered cache controller
package cache_pkg;

  localparam int CACHE_ADDR_W = 32;
  localparam int CACHE_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_REFILL = 2'd2;

  typedef struct packed {
    logic [CACHE_ADDR_W-1:0] addr;
    logic [CACHE_DATA_W-1:0] data;
  } wb_entry_t;

  // Byte-offset width of a cache line: word index bits plus the 2 byte-select bits.
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/cache_write_buffer.sv
// rtl/cache_write_buffer.sv - circular posted-store FIFO, registers on the falling clock edge
module cache_write_buffer
  import cache_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  wb_entry_t                     push_entry,
  output wb_entry_t                     head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(WB_DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(WB_DEPTH+1);

  wb_entry_t         mem_q [WB_DEPTH];
  wb_entry_t         mem_d [WB_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(WB_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full buffer is accepted when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(negedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cache_ctrl_wb.sv
// rtl/cache_ctrl_wb.sv - write-through cache controller with posted write buffer and multi-beat refill
module cache_ctrl_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W     = CACHE_ADDR_W,
  parameter int DATA_W     = CACHE_DATA_W,
  parameter int LINE_WORDS = 4,
  parameter int WB_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          hit,
  input  logic                          ready,
  output logic                          stall,
  output logic                          main_read,
  output logic                          main_write,
  output logic [ADDR_W-1:0]             main_addr,
  output logic [DATA_W-1:0]             main_wdata,
  output logic                          refill,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word,
  output logic                          refill_last,
  output logic                          update,
  output logic                          wb_full,
  output logic                          wb_empty
);

  localparam int OFF = off_w(LINE_WORDS);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int CW  = $clog2(WB_DEPTH+1);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;

  wb_entry_t     push_entry, head;
  logic          buf_full, buf_empty;
  logic [CW-1:0] buf_count;
  logic          store, load, drain_req, push, pop, beat_last;

  assign store      = mem_write & ~mem_read;
  assign load       = mem_read & ~mem_write;
  assign push_entry = '{addr: addr, data: wdata};
  assign beat_last  = (beat_q == BW'(LINE_WORDS-1));

  // The buffer drains in the background whenever no refill owns the memory port.
  assign drain_req = (state_q != ST_REFILL) & ~buf_empty;
  assign pop       = drain_req & ready;
  assign push      = (state_q == ST_IDLE) & store & (~buf_full | pop);

  cache_write_buffer #(
    .WB_DEPTH(WB_DEPTH)
  ) u_wb (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_entry(push_entry),
    .head      (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        // Skip DRAIN when this cycle's pop already empties the buffer.
        if (load & ~hit) begin
          state_d = (buf_empty | ((buf_count == CW'(1)) & pop)) ? ST_REFILL : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop & (buf_count == CW'(1))) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        if (ready) begin
          beat_d = beat_q + BW'(1);
          if (beat_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    main_read   = 1'b0;
    main_write  = 1'b0;
    main_addr   = head.addr;
    main_wdata  = head.data;
    refill      = 1'b0;
    refill_word = beat_q;
    refill_last = 1'b0;
    update      = 1'b0;
    if (reset) begin
      case (state_q)
        ST_IDLE: begin
          stall      = (store & ~push) | (load & ~hit);
          main_write = drain_req;
          update     = push & hit;
        end
        ST_DRAIN: begin
          stall      = 1'b1;
          main_write = drain_req;
        end
        ST_REFILL: begin
          stall       = 1'b1;
          main_read   = 1'b1;
          main_addr   = {addr[ADDR_W-1:OFF], beat_q, 2'b00};
          refill      = ready;
          refill_last = ready & beat_last;
        end
        default: ;
      endcase
    end
  end

  assign wb_full  = buf_full;
  assign wb_empty = buf_empty;

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb/tb_cache_ctrl_wb.sv - self-checking bench for cache_ctrl_wb against a queue-based reference model
module tb_cache_ctrl_wb;

  localparam int LW  = 4;
  localparam int WBD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0, ready = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, main_read, main_write, refill, refill_last, update, wb_full, wb_empty;
  logic [31:0] main_addr, main_wdata;
  logic [1:0]  refill_word;

  always #5 clk = ~clk;

  cache_ctrl_wb #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW), .WB_DEPTH(WBD)
  ) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .hit(hit), .ready(ready),
    .stall(stall), .main_read(main_read), .main_write(main_write),
    .main_addr(main_addr), .main_wdata(main_wdata), .refill(refill),
    .refill_word(refill_word), .refill_last(refill_last), .update(update),
    .wb_full(wb_full), .wb_empty(wb_empty)
  );

  typedef struct packed {
    logic        stall, main_read, main_write;
    logic [31:0] main_addr, main_wdata;
    logic        refill;
    logic [1:0]  refill_word;
    logic        refill_last, update, wb_full, wb_empty;
  } out_t;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  out_t exp_o, obs_o;

  // Reference model: a queue of posted stores plus a mode (0 idle, 1 draining, 2 refilling).
  ent_t        mq[$];
  int          m_mode = 0, m_beat = 0, n_mode, n_beat;
  logic        p_pop, p_push;
  logic [31:0] p_a, p_d;

  task automatic m_reset();
    mq.delete();
    m_mode = 0;
    m_beat = 0;
  endtask

  task automatic m_eval(input logic mr, mw, input logic [31:0] a, d, input logic h, rdy);
    int cnt;
    cnt    = mq.size();
    exp_o  = '0;
    exp_o.wb_empty = (cnt == 0);
    exp_o.wb_full  = (cnt == WBD);
    p_pop  = 1'b0;
    p_push = 1'b0;
    p_a    = a;
    p_d    = d;
    n_mode = m_mode;
    n_beat = m_beat;
    if (m_mode != 2 && cnt > 0) begin
      exp_o.main_write = 1'b1;
      exp_o.main_addr  = mq[0].a;
      exp_o.main_wdata = mq[0].d;
      p_pop = rdy;
    end
    if (m_mode == 0) begin
      if (mw && !mr) begin
        p_push       = (cnt < WBD) || p_pop;
        exp_o.stall  = !p_push;
        exp_o.update = p_push && h;
      end else if (mr && !mw && !h) begin
        exp_o.stall = 1'b1;
        n_mode = (cnt - int'(p_pop) == 0) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      exp_o.stall = 1'b1;
      if (cnt - int'(p_pop) == 0) n_mode = 2;
    end else begin
      exp_o.stall     = 1'b1;
      exp_o.main_read = 1'b1;
      exp_o.main_addr = (a & ~32'(LW*4-1)) + 32'(m_beat*4);
      if (rdy) begin
        exp_o.refill      = 1'b1;
        exp_o.refill_word = 2'(m_beat);
        exp_o.refill_last = (m_beat == LW-1);
        n_beat = (m_beat + 1) % LW;
        if (m_beat == LW-1) n_mode = 0;
      end
    end
  endtask

  task automatic m_commit();
    if (p_pop) void'(mq.pop_front());
    if (p_push) mq.push_back('{a: p_a, d: p_d});
    m_mode = n_mode;
    m_beat = n_beat;
  endtask

  // One core cycle: drive after the rising edge, sample before the falling (register) edge.
  task automatic step(input logic mr, mw, input logic [31:0] a, d, input logic h, rdy);
    #1;
    mem_read = mr; mem_write = mw; addr = a; wdata = d; hit = h; ready = rdy;
    #2;
    m_eval(mr, mw, a, d, h, rdy);
    obs_o = '{stall: stall, main_read: main_read, main_write: main_write,
              main_addr: main_addr, main_wdata: main_wdata, refill: refill,
              refill_word: refill_word, refill_last: refill_last, update: update,
              wb_full: wb_full, wb_empty: wb_empty};
    if (!(exp_o.main_read || exp_o.main_write)) obs_o.main_addr = '0;
    if (!exp_o.main_write) obs_o.main_wdata = '0;
    if (!exp_o.refill) obs_o.refill_word = '0;
    @(negedge clk);
    m_commit();
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    #2;
    if ({stall, main_read, main_write, refill, refill_last, update, wb_full, wb_empty} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {stall, main_read, main_write, refill, refill_last, update, wb_full, wb_empty}, 8'b0000_0001);
    end
    checks++;
    @(negedge clk); #2 reset = 1'b1;
    m_reset();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 32'h500 + 32'(i*4), $urandom, 1'b0, 1'b0);
      if (obs_o !== exp_o) begin
        errors++; $display("FAIL reset_prefill cyc=%0d got=%h exp=%h", cyc, obs_o, exp_o);
      end
      checks++;
    end
    #1 mem_write = 1'b0;
    #1 reset = 1'b0;
    #1;
    if ({wb_empty, main_write, stall} !== 3'b100) begin
      errors++; $display("FAIL reset_discard got=%b exp=%b", {wb_empty, main_write, stall}, 3'b100);
    end
    checks++;
    @(negedge clk); #2 reset = 1'b1;
    m_reset();
    @(posedge clk);
  endtask

  task automatic test_store_full();
    logic [31:0] dv[5];
    for (int i = 0; i < 5; i++) dv[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h10 + 32'(i*4), dv[i], 1'b0, 1'b0);
      if (obs_o !== exp_o) begin
        errors++; $display("FAIL store_fill cyc=%0d got=%h exp=%h", cyc, obs_o, exp_o);
      end
      checks++;
    end
    step(1'b0, 1'b1, 32'h20, dv[4], 1'b0, 1'b0);
    if (obs_o !== exp_o || obs_o.stall !== 1'b1 || obs_o.wb_full !== 1'b1) begin
      errors++; $display("FAIL store_full_stall cyc=%0d got=%h exp=%h", cyc, obs_o, exp_o);
    end
    checks++;
    step(1'b0, 1'b1, 32'h20, dv[4], 1'b0, 1'b1);
    if (obs_o !== exp_o || obs_o.stall !== 1'b0) begin
      errors++; $display("FAIL store_full_release cyc=%0d got=%h exp=%h", cyc, obs_o, exp_o);
    end
    checks++;
    for (int k = 1; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      if (obs_o !== exp_o || obs_o.main_wdata !== dv[k]) begin
        errors++; $display("FAIL store_drain_order k=%0d got=%h exp=%h", k, obs_o.main_wdata, dv[k]);
      end
      checks++;
    end
  endtask

  task automatic test_load_miss();
    step(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1);
    if (obs_o !== exp_o || obs_o.stall !== 1'b1) begin
      errors++; $display("FAIL miss_first cyc=%0d got=%h exp=%h", cyc, obs_o, exp_o);
    end
    checks++;
    for (int b = 0; b < LW; b++) begin
      step(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1);
      if (obs_o !== exp_o || obs_o.main_addr !== 32'h40 + 32'(b*4) || obs_o.refill_word !== 2'(b)
          || obs_o.refill_last !== (b == LW-1)) begin
        errors++; $display("FAIL miss_beat b=%0d got=%h exp=%h", b, obs_o, exp_o);
      end
      checks++;
    end
    step(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b1);
    if (obs_o !== exp_o || obs_o.stall !== 1'b0) begin
      errors++; $display("FAIL miss_release got=%h exp=%h", obs_o, exp_o);
    end
    checks++;
  endtask

  task automatic test_drain_refill();
    int writes = 0, beats = 0;
    logic done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 32'h600 + 32'(i*4), $urandom, 1'b0, 1'b0);
      if (obs_o !== exp_o) begin
        errors++; $display("FAIL drain_store cyc=%0d got=%h exp=%h", cyc, obs_o, exp_o);
      end
      checks++;
    end
    for (int t = 0; t < 12 && !done; t++) begin
      step(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 1'b1);
      if (obs_o !== exp_o || (obs_o.main_read && !obs_o.wb_empty)) begin
        errors++; $display("FAIL drain_seq cyc=%0d got=%h exp=%h", cyc, obs_o, exp_o);
      end
      checks++;
      if (obs_o.main_write) writes++;
      if (obs_o.refill) beats++;
      if (obs_o.refill_last) done = 1'b1;
    end
    if (writes != 2 || beats != LW || !done) begin
      errors++; $display("FAIL drain_counts writes=%0d beats=%0d done=%0b exp 2 %0d 1", writes, beats, done, LW);
    end
    checks++;
    step(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0);
    if (obs_o !== exp_o) begin
      errors++; $display("FAIL drain_release got=%h exp=%h", obs_o, exp_o);
    end
    checks++;
  endtask

  task automatic test_push_pop();
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    step(1'b0, 1'b1, 32'h200, d1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h204, d2, 1'b1, 1'b1);
    if (obs_o !== exp_o || obs_o.update !== 1'b1 || obs_o.main_wdata !== d1) begin
      errors++; $display("FAIL pushpop_same got=%h exp=%h", obs_o, exp_o);
    end
    checks++;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    if (obs_o !== exp_o || obs_o.wb_empty !== 1'b0 || obs_o.main_wdata !== d2) begin
      errors++; $display("FAIL pushpop_order got=%h exp=%h", obs_o, exp_o);
    end
    checks++;
  endtask

  task automatic test_rw_both();
    step(1'b1, 1'b1, 32'h300, $urandom, 1'b0, 1'b1);
    if (obs_o !== exp_o || {obs_o.stall, obs_o.main_read, obs_o.update} !== 3'b000) begin
      errors++; $display("FAIL rw_both got=%h exp=%h", obs_o, exp_o);
    end
    checks++;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    if (obs_o !== exp_o || obs_o.wb_empty !== 1'b1) begin
      errors++; $display("FAIL rw_both_nopush got=%h exp=%h", obs_o, exp_o);
    end
    checks++;
  endtask

  task automatic test_reset_mid_refill();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b1);
    #1 reset = 1'b0;
    #1;
    if ({stall, main_read, refill, wb_empty} !== 4'b0001) begin
      errors++; $display("FAIL reset_mid_refill got=%b exp=%b", {stall, main_read, refill, wb_empty}, 4'b0001);
    end
    checks++;
    @(negedge clk); #2 reset = 1'b1;
    m_reset();
    @(posedge clk);
    step(1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b1);
    if (obs_o !== exp_o || obs_o.main_addr !== 32'h80 || obs_o.refill_word !== 2'd0) begin
      errors++; $display("FAIL reset_beat_zero got=%h exp=%h", obs_o, exp_o);
    end
    checks++;
    for (int i = 0; i < LW; i++) step(1'b1, 1'b0, 32'h88, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0, ($urandom % 3) == 0, $urandom & 32'h3FC, $urandom,
           1'($urandom % 2), ($urandom % 4) != 0);
      if (obs_o !== exp_o) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_o, exp_o);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_store_full();
    test_load_miss();
    test_drain_refill();
    test_push_pop();
    test_rw_both();
    test_reset_mid_refill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
